// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and widths for the IF/ID hazard controller
package pipeline_pkg;

    localparam int ANCHO_REG_DEF  = 5;
    localparam int ANCHO_RESTANTE = 2;

    typedef enum logic [1:0] {
        NORMAL       = 2'b00,
        PARADA_CARGA = 2'b01
    } estado_t;

endpackage

// File: rtl/control_riesgos_if_id_if.sv
// rtl/control_riesgos_if_id_if.sv - pipeline-side signal bundle of the hazard controller
interface control_riesgos_if_id_if
    import pipeline_pkg::*;
#(
    parameter int ANCHO_REG  = ANCHO_REG_DEF,
    parameter int ANCHO_CONT = 16
);
    logic [ANCHO_REG-1:0]  id_rs1;
    logic [ANCHO_REG-1:0]  id_rs2;
    logic                  id_usa_rs1;
    logic                  id_usa_rs2;
    logic [ANCHO_REG-1:0]  ex_rd;
    logic                  ex_lee_mem;
    logic                  salto_tomado;
    logic                  mem_espera;
    logic                  pc_escribe;
    logic                  if_id_escribe;
    logic                  if_id_vaciar;
    logic                  id_ex_burbuja;
    logic [1:0]            estado;
    logic [ANCHO_CONT-1:0] cont_paradas;
    logic [ANCHO_CONT-1:0] cont_vaciados;
    logic [ANCHO_CONT-1:0] cont_esperas;

    modport master (
        output id_rs1, id_rs2, id_usa_rs1, id_usa_rs2, ex_rd, ex_lee_mem,
               salto_tomado, mem_espera,
        input  pc_escribe, if_id_escribe, if_id_vaciar, id_ex_burbuja, estado,
               cont_paradas, cont_vaciados, cont_esperas
    );

    modport slave (
        input  id_rs1, id_rs2, id_usa_rs1, id_usa_rs2, ex_rd, ex_lee_mem,
               salto_tomado, mem_espera,
        output pc_escribe, if_id_escribe, if_id_vaciar, id_ex_burbuja, estado,
               cont_paradas, cont_vaciados, cont_esperas
    );

endinterface

// File: rtl/contador_saturado.sv
// rtl/contador_saturado.sv - event counter that sticks at all-ones instead of wrapping
module contador_saturado #(
    parameter int ANCHO = 16
) (
    input  logic             clk,
    input  logic             reinicio_n,
    input  logic             inc,
    output logic [ANCHO-1:0] valor
);
    logic [ANCHO-1:0] valor_q, valor_d;

    always_comb begin
        valor_d = valor_q;
        if (inc && (valor_q != '1)) begin
            valor_d = valor_q + ANCHO'(1);
        end
    end

    always_ff @(posedge clk or negedge reinicio_n) begin
        if (!reinicio_n) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/control_riesgos_if_id.sv
// rtl/control_riesgos_if_id.sv - load-use / branch-flush / memory-wait sequencing for PC and IF/ID
module control_riesgos_if_id
    import pipeline_pkg::*;
#(
    parameter int ANCHO_REG  = ANCHO_REG_DEF,
    parameter int LAT_CARGA  = 1,
    parameter int ANCHO_CONT = 16
) (
    input  logic                   clk,
    input  logic                   reinicio_n,
    control_riesgos_if_id_if.slave bus
);
    logic [ANCHO_REG-1:0]      rs1, rs2, rd;
    logic                      riesgo;
    estado_t                   estado_q, estado_d;
    logic [ANCHO_RESTANTE-1:0] restante_q, restante_d;
    logic                      pc_escribe, if_id_escribe, if_id_vaciar, id_ex_burbuja;
    logic                      inc_paradas, inc_vaciados, inc_esperas;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.ex_rd;

    assign riesgo = bus.ex_lee_mem && (rd != '0) &&
                    ((bus.id_usa_rs1 && (rs1 == rd)) || (bus.id_usa_rs2 && (rs2 == rd)));

    always_comb begin
        estado_d      = estado_q;
        restante_d    = restante_q;
        pc_escribe    = 1'b0;
        if_id_escribe = 1'b0;
        if_id_vaciar  = 1'b0;
        id_ex_burbuja = 1'b0;
        inc_paradas   = 1'b0;
        inc_vaciados  = 1'b0;
        inc_esperas   = 1'b0;

        if (bus.mem_espera) begin
            inc_esperas = 1'b1;
        end else if (bus.salto_tomado) begin
            pc_escribe    = 1'b1;
            if_id_escribe = 1'b1;
            if_id_vaciar  = 1'b1;
            id_ex_burbuja = 1'b1;
            inc_vaciados  = 1'b1;
            estado_d      = NORMAL;
            restante_d    = '0;
        end else begin
            case (estado_q)
                NORMAL: begin
                    if (riesgo) begin
                        id_ex_burbuja = 1'b1;
                        inc_paradas   = 1'b1;
                        if (LAT_CARGA > 1) begin
                            estado_d   = PARADA_CARGA;
                            restante_d = ANCHO_RESTANTE'(LAT_CARGA - 1);
                        end
                    end else begin
                        pc_escribe    = 1'b1;
                        if_id_escribe = 1'b1;
                    end
                end
                PARADA_CARGA: begin
                    // Hazard is not re-evaluated here: the load is already committed to the countdown.
                    id_ex_burbuja = 1'b1;
                    inc_paradas   = 1'b1;
                    if (restante_q <= ANCHO_RESTANTE'(1)) begin
                        estado_d   = NORMAL;
                        restante_d = '0;
                    end else begin
                        restante_d = restante_q - ANCHO_RESTANTE'(1);
                    end
                end
                default: begin
                    pc_escribe    = 1'b1;
                    if_id_escribe = 1'b1;
                end
            endcase
        end

        if (!(estado_q inside {NORMAL, PARADA_CARGA})) begin
            estado_d   = NORMAL;
            restante_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reinicio_n) begin
        if (!reinicio_n) begin
            estado_q   <= NORMAL;
            restante_q <= '0;
        end else begin
            estado_q   <= estado_d;
            restante_q <= restante_d;
        end
    end

    // Gating with reset keeps the pipeline frozen for the whole reset window, not just after the edge.
    assign bus.pc_escribe    = reinicio_n & pc_escribe;
    assign bus.if_id_escribe = reinicio_n & if_id_escribe;
    assign bus.if_id_vaciar  = reinicio_n & if_id_vaciar;
    assign bus.id_ex_burbuja = reinicio_n & id_ex_burbuja;
    assign bus.estado        = estado_q;

    contador_saturado #(.ANCHO(ANCHO_CONT)) u_cont_paradas (
        .clk(clk), .reinicio_n(reinicio_n), .inc(inc_paradas), .valor(bus.cont_paradas)
    );
    contador_saturado #(.ANCHO(ANCHO_CONT)) u_cont_vaciados (
        .clk(clk), .reinicio_n(reinicio_n), .inc(inc_vaciados), .valor(bus.cont_vaciados)
    );
    contador_saturado #(.ANCHO(ANCHO_CONT)) u_cont_esperas (
        .clk(clk), .reinicio_n(reinicio_n), .inc(inc_esperas), .valor(bus.cont_esperas)
    );

endmodule

// File: tb/tb_control_riesgos_if_id.sv
// tb/tb_control_riesgos_if_id.sv - three parameterisations of the hazard controller against a stall-budget model
module tb_control_riesgos_if_id;

    logic       clk = 1'b0;
    logic       reinicio_n;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, lee, salto, mem;

    always #5 clk = ~clk;

    control_riesgos_if_id_if #(.ANCHO_REG(5), .ANCHO_CONT(16)) if_a ();
    control_riesgos_if_id_if #(.ANCHO_REG(5), .ANCHO_CONT(16)) if_b ();
    control_riesgos_if_id_if #(.ANCHO_REG(5), .ANCHO_CONT(2))  if_c ();

    control_riesgos_if_id #(.ANCHO_REG(5), .LAT_CARGA(1), .ANCHO_CONT(16)) dut_a (
        .clk(clk), .reinicio_n(reinicio_n), .bus(if_a));
    control_riesgos_if_id #(.ANCHO_REG(5), .LAT_CARGA(2), .ANCHO_CONT(16)) dut_b (
        .clk(clk), .reinicio_n(reinicio_n), .bus(if_b));
    control_riesgos_if_id #(.ANCHO_REG(5), .LAT_CARGA(3), .ANCHO_CONT(2)) dut_c (
        .clk(clk), .reinicio_n(reinicio_n), .bus(if_c));

    assign if_a.id_rs1 = rs1; assign if_a.id_rs2 = rs2; assign if_a.ex_rd = rd;
    assign if_a.id_usa_rs1 = u1; assign if_a.id_usa_rs2 = u2; assign if_a.ex_lee_mem = lee;
    assign if_a.salto_tomado = salto; assign if_a.mem_espera = mem;
    assign if_b.id_rs1 = rs1; assign if_b.id_rs2 = rs2; assign if_b.ex_rd = rd;
    assign if_b.id_usa_rs1 = u1; assign if_b.id_usa_rs2 = u2; assign if_b.ex_lee_mem = lee;
    assign if_b.salto_tomado = salto; assign if_b.mem_espera = mem;
    assign if_c.id_rs1 = rs1; assign if_c.id_rs2 = rs2; assign if_c.ex_rd = rd;
    assign if_c.id_usa_rs1 = u1; assign if_c.id_usa_rs2 = u2; assign if_c.ex_lee_mem = lee;
    assign if_c.salto_tomado = salto; assign if_c.mem_espera = mem;

    // Observed {pc_escribe, if_id_escribe, if_id_vaciar, id_ex_burbuja, estado} and {paradas, vaciados, esperas}
    logic [5:0]  obs_ctrl [3];
    logic [47:0] obs_cnt  [3];
    assign obs_ctrl[0] = {if_a.pc_escribe, if_a.if_id_escribe, if_a.if_id_vaciar, if_a.id_ex_burbuja, if_a.estado};
    assign obs_ctrl[1] = {if_b.pc_escribe, if_b.if_id_escribe, if_b.if_id_vaciar, if_b.id_ex_burbuja, if_b.estado};
    assign obs_ctrl[2] = {if_c.pc_escribe, if_c.if_id_escribe, if_c.if_id_vaciar, if_c.id_ex_burbuja, if_c.estado};
    assign obs_cnt[0]  = {if_a.cont_paradas, if_a.cont_vaciados, if_a.cont_esperas};
    assign obs_cnt[1]  = {if_b.cont_paradas, if_b.cont_vaciados, if_b.cont_esperas};
    assign obs_cnt[2]  = {14'd0, if_c.cont_paradas, 14'd0, if_c.cont_vaciados, 14'd0, if_c.cont_esperas};

    // Reference: each core has a budget of frozen cycles still owed to the load in flight.
    int lat  [3] = '{1, 2, 3};
    int maxc [3] = '{65535, 65535, 3};
    int owed [3];
    int cp [3], cv [3], ce [3];
    int n_cmp = 0;
    int n_err = 0;

    function automatic bit hazard();
        return lee && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    function automatic logic [5:0] exp_ctrl(int k);
        logic [1:0] st;
        st = (owed[k] > 0) ? 2'b01 : 2'b00;
        if (!reinicio_n)               return 6'b000000;
        if (mem)                       return {4'b0000, st};
        if (salto)                     return {4'b1111, st};
        if (owed[k] > 0 || hazard())   return {4'b0001, st};
        return {4'b1100, st};
    endfunction

    function automatic logic [47:0] exp_cnt(int k);
        if (!reinicio_n) return 48'd0;
        return {cp[k][15:0], cv[k][15:0], ce[k][15:0]};
    endfunction

    function automatic int sat(int v, int k);
        return (v >= maxc[k]) ? v : v + 1;
    endfunction

    task automatic advance();
        bit h;
        h = hazard();
        for (int k = 0; k < 3; k++) begin
            if (!reinicio_n) begin
                owed[k] = 0; cp[k] = 0; cv[k] = 0; ce[k] = 0;
            end else if (mem) begin
                ce[k] = sat(ce[k], k);
            end else if (salto) begin
                owed[k] = 0; cv[k] = sat(cv[k], k);
            end else if (owed[k] > 0) begin
                owed[k]--; cp[k] = sat(cp[k], k);
            end else if (h) begin
                owed[k] = lat[k] - 1; cp[k] = sat(cp[k], k);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_quiet();
        rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
        u1 = 1'b0; u2 = 1'b0; lee = 1'b0; salto = 1'b0; mem = 1'b0;
    endtask

    task automatic set_hazard(logic [4:0] r);
        set_quiet();
        lee = 1'b1; rd = r; rs1 = r; u1 = 1'b1;
    endtask

    task automatic test_reset();
        reinicio_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            {rs1, rs2, rd} = 15'($urandom);
            {u1, u2, lee, salto, mem} = 5'($urandom);
            #4;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs_ctrl[k] !== 6'b000000) begin
                    n_err++; $display("FAIL reset_ctrl dut%0d cyc%0d: got %b want 000000", k, c, obs_ctrl[k]);
                end
                n_cmp++;
                if (obs_cnt[k] !== 48'd0) begin
                    n_err++; $display("FAIL reset_cnt dut%0d cyc%0d: got %h want 0", k, c, obs_cnt[k]);
                end
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        reinicio_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) set_hazard(5'd5); else set_quiet();
            #4;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs_ctrl[k] !== exp_ctrl(k)) begin
                    n_err++; $display("FAIL load_use_ctrl dut%0d cyc%0d: got %b want %b", k, c, obs_ctrl[k], exp_ctrl(k));
                end
                n_cmp++;
                if (obs_cnt[k] !== exp_cnt(k)) begin
                    n_err++; $display("FAIL load_use_cnt dut%0d cyc%0d: got %h want %h", k, c, obs_cnt[k], exp_cnt(k));
                end
            end
            advance();
        end
        n_cmp++;
        if (if_a.cont_paradas !== 16'd1 || if_b.cont_paradas !== 16'd2) begin
            n_err++; $display("FAIL load_use_stall_count: got %0d/%0d want 1/2", if_a.cont_paradas, if_b.cont_paradas);
        end
        set_hazard(5'd0);
        #4;
        n_cmp++;
        if (obs_ctrl[1] !== 6'b110000) begin
            n_err++; $display("FAIL rd_zero_no_stall: got %b want 110000", obs_ctrl[1]);
        end
        advance();
    endtask

    task automatic test_branch_abort();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) set_hazard(5'd9); else set_quiet();
            salto = (c == 1);
            #4;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs_ctrl[k] !== exp_ctrl(k)) begin
                    n_err++; $display("FAIL branch_ctrl dut%0d cyc%0d: got %b want %b", k, c, obs_ctrl[k], exp_ctrl(k));
                end
            end
            n_cmp++;
            if (c == 1 && obs_ctrl[1] !== 6'b111101) begin
                n_err++; $display("FAIL branch_in_stall: got %b want 111101", obs_ctrl[1]);
            end
            advance();
        end
        n_cmp++;
        if (if_b.estado !== 2'b00) begin
            n_err++; $display("FAIL branch_back_normal: got %b want 00", if_b.estado);
        end
    endtask

    task automatic test_mem_freeze();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) set_hazard(5'd17); else set_quiet();
            mem = (c >= 1 && c <= 4);
            if (mem) begin
                lee = 1'b1; rd = 5'd3; rs2 = 5'd3; u2 = 1'b1; salto = 1'b1;
            end
            #4;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs_ctrl[k] !== exp_ctrl(k)) begin
                    n_err++; $display("FAIL mem_ctrl dut%0d cyc%0d: got %b want %b", k, c, obs_ctrl[k], exp_ctrl(k));
                end
                n_cmp++;
                if (obs_cnt[k] !== exp_cnt(k)) begin
                    n_err++; $display("FAIL mem_cnt dut%0d cyc%0d: got %h want %h", k, c, obs_cnt[k], exp_cnt(k));
                end
            end
            advance();
        end
        n_cmp++;
        if (if_b.cont_esperas !== 16'd4) begin
            n_err++; $display("FAIL mem_wait_count: got %0d want 4", if_b.cont_esperas);
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 5; c++) begin
            set_quiet();
            salto = 1'b1;
            #4;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs_cnt[k] !== exp_cnt(k)) begin
                    n_err++; $display("FAIL sat_cnt dut%0d cyc%0d: got %h want %h", k, c, obs_cnt[k], exp_cnt(k));
                end
            end
            advance();
        end
        n_cmp++;
        if (if_c.cont_vaciados !== 2'd3) begin
            n_err++; $display("FAIL flush_saturates: got %0d want 3", if_c.cont_vaciados);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reinicio_n = ($urandom_range(63) != 0);
            rs1 = 5'($urandom_range(3)); rs2 = 5'($urandom_range(3)); rd = 5'($urandom_range(3));
            u1 = 1'($urandom); u2 = 1'($urandom); lee = 1'($urandom);
            salto = ($urandom_range(7) == 0);
            mem   = ($urandom_range(5) == 0);
            #4;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs_ctrl[k] !== exp_ctrl(k)) begin
                    n_err++; $display("FAIL random_ctrl dut%0d cyc%0d: got %b want %b", k, c, obs_ctrl[k], exp_ctrl(k));
                end
                n_cmp++;
                if (obs_cnt[k] !== exp_cnt(k)) begin
                    n_err++; $display("FAIL random_cnt dut%0d cyc%0d: got %h want %h", k, c, obs_cnt[k], exp_cnt(k));
                end
            end
            advance();
        end
    endtask

    initial begin
        reinicio_n = 1'b0;
        set_quiet();
        for (int k = 0; k < 3; k++) begin
            owed[k] = 0; cp[k] = 0; cv[k] = 0; ce[k] = 0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_abort();
        test_mem_freeze();
        test_saturation();
        test_random();
        reinicio_n = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
